// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and helpers for the hazard / forwarding controller.
package hazard_forward_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } lu_state_e;

    localparam int REG_ZERO = 0;

    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_src_match.sv
// Priority match of one EX operand against all forwarding sources (youngest wins).
module fwd_src_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC-1:0]        src_wb,
    input  logic [REG_AW-1:0]         op_rs,
    output logic [SEL_W-1:0]          sel
);

    // Walk oldest to youngest so the lowest index match is the last write.
    always_comb begin
        sel = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (src_wb[k] && (src_rd[k*REG_AW +: REG_AW] == op_rs) &&
                (op_rs != REG_AW'(REG_ZERO))) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding selects plus load-use stall/bubble/freeze control.
// Optional performance counters are enabled by defining FWD_PERF_CNT_EN.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int LU_BUBBLES = 1,
    localparam int SEL_W      = sel_width(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_AW-1:0]         id_rs1,
    input  logic [REG_AW-1:0]         id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_AW-1:0]         ex_rs1,
    input  logic [REG_AW-1:0]         ex_rs2,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_wb,
    input  logic                      ex_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC-1:0]        src_wb,
    input  logic                      mem_busy,
    output logic [SEL_W-1:0]          fwd_a_sel,
    output logic [SEL_W-1:0]          fwd_b_sel,
    output logic                      stall_if_id,
    output logic                      bubble_id_ex,
    output logic                      freeze_ex,
    output logic [31:0]               lu_cnt,
    output logic [31:0]               fwd_cnt
);

    lu_state_e        state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] match_a, match_b;
    logic             lu_hazard;
    logic             stall_raw, bubble_raw, freeze_raw;

    fwd_src_match #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_match_a (
        .src_rd (src_rd),
        .src_wb (src_wb),
        .op_rs  (ex_rs1),
        .sel    (match_a)
    );

    fwd_src_match #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_match_b (
        .src_rd (src_rd),
        .src_wb (src_wb),
        .op_rs  (ex_rs2),
        .sel    (match_b)
    );

    assign lu_hazard = ex_wb && ex_is_load && (ex_rd != REG_AW'(REG_ZERO)) &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

    // A memory freeze overrides everything and holds the bubble sequence in place.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;
        freeze_raw = 1'b0;
        if (mem_busy) begin
            freeze_raw = 1'b1;
            stall_raw  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_hazard) begin
                        stall_raw  = 1'b1;
                        bubble_raw = 1'b1;
                        if (LU_BUBBLES > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = 2'(LU_BUBBLES - 1);
                        end
                    end
                end
                LU_STALL: begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low for as long as reset is held, not just at the next edge.
    assign fwd_a_sel    = rst_n ? match_a : '0;
    assign fwd_b_sel    = rst_n ? match_b : '0;
    assign stall_if_id  = rst_n & stall_raw;
    assign bubble_id_ex = rst_n & bubble_raw;
    assign freeze_ex    = rst_n & freeze_raw;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        fwd_cnt_d = fwd_cnt_q;
        if (!mem_busy && (state_q == RUN) && lu_hazard && (lu_cnt_q != 32'hFFFF_FFFF)) begin
            lu_cnt_d = lu_cnt_q + 32'd1;
        end
        if (!mem_busy && ((match_a != '0) || (match_b != '0)) &&
            (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q  <= 32'd0;
            fwd_cnt_q <= 32'd0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    assign lu_cnt  = lu_cnt_q;
    assign fwd_cnt = fwd_cnt_q;
`else
    assign lu_cnt  = 32'd0;
    assign fwd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomized and directed self-checking bench for hazard_forward_ctrl against a bubble-budget model.
module tb_hazard_forward_ctrl;

    localparam int REG_AW     = 5;
    localparam int NUM_SRC    = 2;
    localparam int LU_BUBBLES = 2;
    localparam int SEL_W      = $clog2(NUM_SRC + 1);

    logic                      clk;
    logic                      rst_n;
    logic [REG_AW-1:0]         id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic                      id_rs1_used, id_rs2_used, ex_wb, ex_is_load;
    logic [NUM_SRC*REG_AW-1:0] src_rd;
    logic [NUM_SRC-1:0]        src_wb;
    logic                      mem_busy;
    logic [SEL_W-1:0]          fwd_a_sel, fwd_b_sel;
    logic                      stall_if_id, bubble_id_ex, freeze_ex;
    logic [31:0]               lu_cnt, fwd_cnt;

    int checks;
    int failures;

    int          bubbles_left;
    int unsigned exp_lu;
    int unsigned exp_fwd;

    hazard_forward_ctrl #(
        .REG_AW     (REG_AW),
        .NUM_SRC    (NUM_SRC),
        .LU_BUBBLES (LU_BUBBLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_wb        (ex_wb),
        .ex_is_load   (ex_is_load),
        .src_rd       (src_rd),
        .src_wb       (src_wb),
        .mem_busy     (mem_busy),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .freeze_ex    (freeze_ex),
        .lu_cnt       (lu_cnt),
        .fwd_cnt      (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(
        input int r_id1, input bit u1, input int r_id2, input bit u2,
        input int r_ex1, input int r_ex2, input int r_exrd, input bit wb, input bit ld,
        input int s0, input int s1, input int swb, input bit busy);
        id_rs1      = REG_AW'(r_id1);
        id_rs1_used = u1;
        id_rs2      = REG_AW'(r_id2);
        id_rs2_used = u2;
        ex_rs1      = REG_AW'(r_ex1);
        ex_rs2      = REG_AW'(r_ex2);
        ex_rd       = REG_AW'(r_exrd);
        ex_wb       = wb;
        ex_is_load  = ld;
        src_rd      = {REG_AW'(s1), REG_AW'(s0)};
        src_wb      = NUM_SRC'(swb);
        mem_busy    = busy;
    endtask

    // Youngest writing source with a matching, nonzero destination.
    function automatic int modelSel(input int rs);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_wb[k] && (int'(src_rd[k*REG_AW +: REG_AW]) == rs) && (rs != 0))
                return k + 1;
        end
        return 0;
    endfunction

    function automatic bit modelHazard();
        if (!(ex_wb && ex_is_load) || (ex_rd == 0))
            return 1'b0;
        return (id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd));
    endfunction

    function automatic int unsigned expLu();
`ifdef FWD_PERF_CNT_EN
        return exp_lu;
`else
        return 0;
`endif
    endfunction

    function automatic int unsigned expFwd();
`ifdef FWD_PERF_CNT_EN
        return exp_fwd;
`else
        return 0;
`endif
    endfunction

    task automatic resetModel();
        bubbles_left = 0;
        exp_lu       = 0;
        exp_fwd      = 0;
    endtask

    // Inputs were applied at the preceding falling edge; check, then advance the model across the rising edge.
    task automatic doCycle(input string tag);
        int  a_exp, b_exp;
        bit  hz, bubble_exp;
        #1;
        a_exp      = modelSel(int'(ex_rs1));
        b_exp      = modelSel(int'(ex_rs2));
        hz         = modelHazard();
        bubble_exp = !mem_busy && ((bubbles_left > 0) || hz);
        checkOutput({tag, ".fwd_a"}, 64'(fwd_a_sel), 64'(a_exp));
        checkOutput({tag, ".fwd_b"}, 64'(fwd_b_sel), 64'(b_exp));
        checkOutput({tag, ".bubble"}, 64'(bubble_id_ex), 64'(bubble_exp));
        checkOutput({tag, ".stall"}, 64'(stall_if_id), 64'(mem_busy || bubble_exp));
        checkOutput({tag, ".freeze"}, 64'(freeze_ex), 64'(mem_busy));
        checkOutput({tag, ".lu_cnt"}, 64'(lu_cnt), 64'(expLu()));
        checkOutput({tag, ".fwd_cnt"}, 64'(fwd_cnt), 64'(expFwd()));
        if (!mem_busy) begin
            if (bubbles_left > 0) begin
                bubbles_left--;
            end else if (hz) begin
                bubbles_left = LU_BUBBLES - 1;
                if (exp_lu != 32'hFFFF_FFFF) exp_lu++;
            end
            if (((a_exp != 0) || (b_exp != 0)) && (exp_fwd != 32'hFFFF_FFFF)) exp_fwd++;
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        #1;
        checkOutput({tag, ".fwd_a"}, 64'(fwd_a_sel), 64'd0);
        checkOutput({tag, ".fwd_b"}, 64'(fwd_b_sel), 64'd0);
        checkOutput({tag, ".stall"}, 64'(stall_if_id), 64'd0);
        checkOutput({tag, ".bubble"}, 64'(bubble_id_ex), 64'd0);
        checkOutput({tag, ".freeze"}, 64'(freeze_ex), 64'd0);
        checkOutput({tag, ".lu_cnt"}, 64'(lu_cnt), 64'd0);
        checkOutput({tag, ".fwd_cnt"}, 64'(fwd_cnt), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetModel();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 3, 3, 0, 0, 0, 3, 3, 3, 1);
        checkResetOutputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed forwarding priority and x0");
        applyStimulus(0, 0, 0, 0, 5, 9, 0, 0, 0, 5, 5, 3, 0);
        doCycle("youngest_wins");
        checkOutput("youngest_wins.sel1", 64'(fwd_a_sel), 64'd1);
        applyStimulus(0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 6, 3, 0);
        doCycle("x0_not_fwd");
        applyStimulus(0, 0, 0, 0, 6, 8, 0, 0, 0, 4, 8, 2, 0);
        doCycle("older_src");

        $display("[TB] directed load-use with two bubbles");
        resetModel();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        applyStimulus(7, 1, 2, 0, 1, 2, 7, 1, 1, 0, 0, 0, 0);
        doCycle("lu_first");
        doCycle("lu_second");
        applyStimulus(3, 1, 4, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        doCycle("lu_after");
        checkOutput("lu_one_entry", 64'(lu_cnt), 64'(expLu()));

        $display("[TB] directed load-use across a memory freeze");
        applyStimulus(7, 1, 2, 0, 1, 2, 7, 1, 1, 0, 0, 0, 0);
        doCycle("frz_entry");
        applyStimulus(7, 1, 2, 0, 1, 2, 7, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) doCycle($sformatf("frz_busy%0d", i));
        applyStimulus(7, 1, 2, 0, 1, 2, 7, 1, 1, 0, 0, 0, 0);
        doCycle("frz_last_bubble");
        applyStimulus(3, 1, 4, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        doCycle("frz_run");

        $display("[TB] reset in the middle of the stall");
        applyStimulus(7, 1, 2, 0, 4, 2, 7, 1, 1, 4, 0, 1, 0);
        doCycle("rst_entry");
        rst_n = 1'b0;
        checkResetOutputs("rst_mid");
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3, 1, 4, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        doCycle("rst_release");

        $display("[TB] 100 forwarding cycles");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 1, 0);
            doCycle("fwd_run");
        end
`ifdef FWD_PERF_CNT_EN
        checkOutput("fwd_cnt_100", 64'(fwd_cnt), 64'd100);
`else
        checkOutput("fwd_cnt_100", 64'(fwd_cnt), 64'd0);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
            doCycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
